// File: rtl/b_counter_pkg.sv
// Shared definitions for the lab's binary counter/timer blocks:
// state encoding, count width and default prescaler width.
package b_counter_pkg;

    localparam int COUNT_W           = 4;
    localparam int DEFAULT_DIV_WIDTH = 26;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/b_prescaler.sv
// Free-running prescaler that produces a one-cycle tick every 2^DIV_WIDTH
// enabled cycles; clr wins over en so callers can restart the period.
module b_prescaler
    import b_counter_pkg::*;
#(
    parameter int DIV_WIDTH = DEFAULT_DIV_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] div_d;

    always_comb begin
        div_d = div_q;
        if (clr) begin
            div_d = '0;
        end else if (en) begin
            div_d = div_q + DIV_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    assign tick = en & (&div_q);

endmodule

// File: rtl/b_4bit_bin_downcounter.sv
// Programmable 4-bit down counter/timer with one-shot or auto-reload
// behaviour, paced by an internal prescaler instead of a derived clock.
module b_4bit_bin_downcounter
    import b_counter_pkg::*;
#(
    parameter int DIV_WIDTH = DEFAULT_DIV_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [COUNT_W-1:0] load_val,
    input  logic               start,
    input  logic               stop,
    input  logic               reload_en,
    output logic [COUNT_W-1:0] count,
    output logic               tc,
    output logic               busy,
    output logic               done
);

    state_t             state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [COUNT_W-1:0] reload_q, reload_d;
    logic               tc_q, tc_d;
    logic               pre_clr;
    logic               tick;

    b_prescaler #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_prescaler (
        .clk  (clk),
        .reset(reset),
        .en   (state_q == RUN),
        .clr  (pre_clr),
        .tick (tick)
    );

    // load overrides everything, including a tc due in the same cycle
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        tc_d     = 1'b0;
        pre_clr  = 1'b0;

        if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            pre_clr  = 1'b1;
            state_d  = IDLE;
        end else begin
            if (tick) begin
                if (count_q > COUNT_W'(1)) begin
                    count_d = count_q - COUNT_W'(1);
                end else if (count_q == COUNT_W'(1)) begin
                    count_d = '0;
                    tc_d    = 1'b1;
                    if (!reload_en) begin
                        state_d = DONE;
                    end
                end else begin
                    count_d = reload_q;
                end
            end

            if (stop) begin
                if (state_q == RUN) begin
                    state_d = PAUSE;
                end
            end else if (start) begin
                case (state_q)
                    IDLE: begin
                        if (count_q != '0) begin
                            pre_clr = 1'b1;
                            state_d = RUN;
                        end else begin
                            state_d = DONE;
                        end
                    end
                    PAUSE: state_d = RUN;
                    DONE: begin
                        if (reload_q != '0) begin
                            count_d = reload_q;
                            pre_clr = 1'b1;
                            state_d = RUN;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            tc_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            tc_q     <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = (state_q == RUN);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_b_4bit_bin_downcounter.sv
// Directed, table-driven bench for the 4-bit down counter with DIV_WIDTH=2
// (one tick every 4 clk cycles).
module tb_b_4bit_bin_downcounter;

    typedef struct {
        logic       load;
        logic [3:0] load_val;
        logic       start;
        logic       stop;
        logic       reload_en;
        int         reps;
        logic [3:0] exp_count;
        logic       exp_tc;
        logic       exp_busy;
        logic       exp_done;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       load;
    logic [3:0] load_val;
    logic       start;
    logic       stop;
    logic       reload_en;
    logic [3:0] count;
    logic       tc;
    logic       busy;
    logic       done;

    int total;
    int bad;

    vec_t vecs[17];

    b_4bit_bin_downcounter #(
        .DIV_WIDTH(2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .stop     (stop),
        .reload_en(reload_en),
        .count    (count),
        .tc       (tc),
        .busy     (busy),
        .done     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic ld, input logic [3:0] lv, input logic st,
                                input logic sp, input logic re, input int reps,
                                input logic [3:0] ec, input logic et, input logic eb,
                                input logic ed);
        vec_t v;
        v.load      = ld;
        v.load_val  = lv;
        v.start     = st;
        v.stop      = sp;
        v.reload_en = re;
        v.reps      = reps;
        v.exp_count = ec;
        v.exp_tc    = et;
        v.exp_busy  = eb;
        v.exp_done  = ed;
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs; pulses are dropped again after the edge.
    task automatic apply_stimulus(input logic ld, input logic [3:0] lv, input logic st,
                                  input logic sp, input logic re);
        load      = ld;
        load_val  = lv;
        start     = st;
        stop      = sp;
        reload_en = re;
        step();
        load  = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic check_output(input string name, input logic [3:0] ec, input logic et,
                                input logic eb, input logic ed);
        total++;
        if (count !== ec) begin
            bad++;
            $display("[TB] FAIL %s count got=%0d exp=%0d", name, count, ec);
        end
        total++;
        if (tc !== et) begin
            bad++;
            $display("[TB] FAIL %s tc got=%b exp=%b", name, tc, et);
        end
        total++;
        if (busy !== eb) begin
            bad++;
            $display("[TB] FAIL %s busy got=%b exp=%b", name, busy, eb);
        end
        total++;
        if (done !== ed) begin
            bad++;
            $display("[TB] FAIL %s done got=%b exp=%b", name, done, ed);
        end
    endtask

    task automatic reset_dut();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b0;
        load      = 1'b0;
        load_val  = 4'd0;
        start     = 1'b0;
        stop      = 1'b0;
        reload_en = 1'b0;

        // one-shot countdown from 3
        vecs[0]  = mk(1'b1, 4'd3, 1'b0, 1'b0, 1'b0, 1, 4'd3, 1'b0, 1'b0, 1'b0);
        vecs[1]  = mk(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1, 4'd3, 1'b0, 1'b1, 1'b0);
        vecs[2]  = mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3, 4'd3, 1'b0, 1'b1, 1'b0);
        vecs[3]  = mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4, 4'd2, 1'b0, 1'b1, 1'b0);
        vecs[4]  = mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4, 4'd1, 1'b0, 1'b1, 1'b0);
        vecs[5]  = mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1, 4'd0, 1'b1, 1'b0, 1'b1);
        vecs[6]  = mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 3, 4'd0, 1'b0, 1'b0, 1'b1);
        // auto-reload from 2
        vecs[7]  = mk(1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 1, 4'd2, 1'b0, 1'b0, 1'b0);
        vecs[8]  = mk(1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1, 4'd2, 1'b0, 1'b1, 1'b0);
        vecs[9]  = mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 3, 4'd2, 1'b0, 1'b1, 1'b0);
        vecs[10] = mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4, 4'd1, 1'b0, 1'b1, 1'b0);
        vecs[11] = mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1, 4'd0, 1'b1, 1'b1, 1'b0);
        vecs[12] = mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 3, 4'd0, 1'b0, 1'b1, 1'b0);
        vecs[13] = mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4, 4'd2, 1'b0, 1'b1, 1'b0);
        vecs[14] = mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4, 4'd1, 1'b0, 1'b1, 1'b0);
        vecs[15] = mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1, 4'd0, 1'b1, 1'b1, 1'b0);
        vecs[16] = mk(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1, 4'd0, 1'b0, 1'b1, 1'b0);

        #2;
        check_output("reset_state", 4'd0, 1'b0, 1'b0, 1'b0);
        step();
        reset = 1'b1;
        step();
        check_output("after_release", 4'd0, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 17; i++) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                if (r == 0)
                    apply_stimulus(vecs[i].load, vecs[i].load_val, vecs[i].start,
                                   vecs[i].stop, vecs[i].reload_en);
                else
                    apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0, vecs[i].reload_en);
                check_output($sformatf("vec%0d.%0d", i, r), vecs[i].exp_count,
                             vecs[i].exp_tc, vecs[i].exp_busy, vecs[i].exp_done);
            end
        end

        // pause and resume: stop one cycle after the first decrement
        apply_stimulus(1'b1, 4'd9, 1'b0, 1'b0, 1'b0);
        check_output("pause_load", 4'd9, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        check_output("pause_start", 4'd9, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
            check_output("pause_run9", 4'd9, 1'b0, 1'b1, 1'b0);
        end
        apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        check_output("pause_first_dec", 4'd8, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        check_output("pause_stop", 4'd8, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
            check_output("pause_hold", 4'd8, 1'b0, 1'b0, 1'b0);
        end
        apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        check_output("resume", 4'd8, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
            check_output("resume_wait", 4'd8, 1'b0, 1'b1, 1'b0);
        end
        apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        check_output("resume_dec", 4'd7, 1'b0, 1'b1, 1'b0);

        // stop beats start when both arrive in PAUSE
        apply_stimulus(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        check_output("stop_again", 4'd7, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
        check_output("start_stop_prio", 4'd7, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        check_output("still_paused", 4'd7, 1'b0, 1'b0, 1'b0);

        // load lands on the tick that would have produced tc
        apply_stimulus(1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        check_output("tcload_load1", 4'd1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        check_output("tcload_start", 4'd1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
            check_output("tcload_run", 4'd1, 1'b0, 1'b1, 1'b0);
        end
        apply_stimulus(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
        check_output("tcload_load5", 4'd5, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        check_output("tcload_idle", 4'd5, 1'b0, 1'b0, 1'b0);

        // start with count 0 goes straight to DONE without tc
        reset_dut();
        check_output("zero_reset", 4'd0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        check_output("zero_start", 4'd0, 1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        check_output("zero_hold", 4'd0, 1'b0, 1'b0, 1'b1);
        apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        check_output("zero_restart", 4'd0, 1'b0, 1'b0, 1'b1);

        // asynchronous reset in the middle of a run
        apply_stimulus(1'b1, 4'd6, 1'b0, 1'b0, 1'b0);
        check_output("arst_load", 4'd6, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        check_output("arst_run", 4'd6, 1'b0, 1'b1, 1'b0);
        #3;
        reset = 1'b0;
        #1;
        check_output("arst_async", 4'd0, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        step();
        check_output("arst_idle", 4'd0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        check_output("arst_start", 4'd0, 1'b0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/b_4bit_bin_downcounter.md
# b_4bit_bin_downcounter

Programmable 4-bit binary down counter/timer, the decrementing counterpart to the lab's 4-bit up counter. An internal prescaler on `clk` generates count ticks, so no derived clock is used. The counter loads a start value, counts down to zero, and flags terminal count. It either stops at zero or auto-reloads, and drives board LEDs and downstream sequencing logic.

## Interface
- `DIV_WIDTH`, default 26: prescaler width; one tick every 2^DIV_WIDTH `clk` cycles while running.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `reset`  in  1  asynchronous active-low reset.
- `load`  in  1  single-cycle pulse; captures `load_val` into the count and reload registers.
- `load_val`  in  4  start/reload value.
- `start`  in  1  single-cycle pulse; begins or resumes counting.
- `stop`  in  1  single-cycle pulse; pauses counting.
- `reload_en`  in  1  level; 1 = auto-reload at zero, 0 = one-shot.
- `count`  out  4  current count value, registered.
- `tc`  out  1  terminal-count pulse, one cycle wide, registered.
- `busy`  out  1  high while in state RUN.
- `done`  out  1  high while in state DONE.

## Operation
- States are IDLE, RUN, PAUSE and DONE.
- Reset (`reset`=0, asynchronous):
  - state = IDLE.
  - `count` = 0, reload register = 0, prescaler = 0.
  - `tc` = `busy` = `done` = 0.
- Priority when inputs coincide: `load` > `stop` > `start`.
- `load`, accepted in any state:
  - `count` and reload register are set to `load_val`.
  - Prescaler cleared; state goes to IDLE.
  - A `tc` that would fire in the same cycle is suppressed.
- `start` in IDLE:
  - `count` != 0: go to RUN with the prescaler cleared.
  - `count` == 0: go to DONE; no `tc` is pulsed.
- `start` in PAUSE: go to RUN; the prescaler resumes from its held value.
- `start` in DONE:
  - reload register != 0: `count` is set to the reload value, prescaler cleared, go to RUN.
  - reload register == 0: remain in DONE.
- `start` in RUN is ignored.
- `stop` in RUN: go to PAUSE; `count` and prescaler are held. `stop` in any other state is ignored.
- Tick: asserted when state is RUN and the prescaler is all ones. On a tick the prescaler wraps to 0. The prescaler increments only in RUN.
- On a tick in RUN:
  - `count` > 1: `count` decrements by 1.
  - `count` == 1: `count` becomes 0 and `tc` pulses. If `reload_en`=0, go to DONE; otherwise remain in RUN.
  - `count` == 0 (only reachable with auto-reload): `count` is set to the reload value. There is no `tc` on the reload tick.
- `reload_en` is sampled at the tick where `count` reaches 0. It may change at any time.
- Arithmetic is 4-bit unsigned. `count` never wraps 0 -> 15; leaving 0 only happens through reload or load.

## Timing
- All outputs are registered and change only on the rising edge of `clk` or on reset assertion.
- `load` -> `count` reflects `load_val` in the next cycle.
- `start` from IDLE: the first decrement appears 2^DIV_WIDTH cycles after `busy` rises.
- `tc` is high in the same cycle `count` first shows 0. It stays high for exactly 1 cycle.
- `done` rises together with `tc` in one-shot mode. `busy` falls in that same cycle.
- With auto-reload, `count` holds 0 for one full tick period before it reloads.
- Reset asserted mid-count: all outputs clear immediately. After release, the block sits in IDLE awaiting `load` and `start`.

## Structure
- Shared package/include `b_counter_pkg` holds:
  - the state encoding (IDLE=0, RUN=1, PAUSE=2, DONE=3);
  - count width constant 4;
  - default `DIV_WIDTH`.
- Sub-module `b_prescaler` (parameter `DIV_WIDTH`):
  - inputs `clk`, `reset`, `en`, `clr`;
  - output `tick` = `en` and counter all ones;
  - `clr` has priority over `en`.
- Top level contains the FSM, the count/reload registers and the output registers.

## Test plan
All scenarios run with `DIV_WIDTH`=2, so one tick every 4 cycles.
- One-shot countdown: reset, `load` `load_val`=3, `start`, `reload_en`=0 -> `count` steps 3,2,1,0 at 4-cycle spacing. One-cycle `tc` when `count`=0; `done`=1 and `busy`=0 from that cycle on.
- Auto-reload: `load` 2, `reload_en`=1, `start` -> `count` sequence 2,1,0,2,1,0 at 4-cycle spacing. `tc` pulses at each 0; `done` stays 0.
- Pause/resume: `load` 9, `start`, `stop` one cycle after the first decrement -> `count` holds 8 for 20 cycles. `start` -> the next decrement arrives 3 cycles after resume.
- Priority: `start` and `stop` in the same cycle from PAUSE -> stays in PAUSE. `load` 5 in the same cycle as a `tc`-producing tick -> `count`=5, no `tc`, state IDLE.
- Zero start: reset, `start` with `count`=0 -> `done`=1 next cycle, `tc` never asserts. A later `start` in DONE with reload register 0 -> remains in DONE.
- Asynchronous reset: assert `reset`=0 mid-cycle during RUN with `count`=6 -> `count`=0 and `busy`=0 before the next `clk` edge. After release, `start` alone keeps `count` at 0 and goes to DONE.
